// File: rtl/traffic_pkg.sv
// Shared lamp codes, state encoding and default timing for the intersection
// controller.
//   LAMP_*      : 4-bit lamp codes {left arrow, green, yellow, red}
//   state_t     : controller state, fixed 4-bit codes (also driven on phase)
//   DEF_*       : default phase lengths in clock cycles (legal range 1..31)
package traffic_pkg;

    localparam int unsigned LAMP_W  = 4;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TIMER_W = 5;

    localparam logic [LAMP_W-1:0] LAMP_RED      = 4'b0001;
    localparam logic [LAMP_W-1:0] LAMP_YELLOW   = 4'b0010;
    localparam logic [LAMP_W-1:0] LAMP_GREEN    = 4'b0100;
    localparam logic [LAMP_W-1:0] LAMP_LEFT_RED = 4'b1001;

    typedef enum logic [STATE_W-1:0] {
        NS_LEFT   = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        CLEAR_NS  = 4'd3,
        EW_LEFT   = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
        CLEAR_EW  = 4'd7,
        PREEMPT   = 4'd8,
        RELEASE   = 4'd9
    } state_t;

    localparam int unsigned DEF_LEFT_T    = 5;
    localparam int unsigned DEF_GREEN_MIN = 6;
    localparam int unsigned DEF_GREEN_MAX = 15;
    localparam int unsigned DEF_YELLOW_T  = 3;
    localparam int unsigned DEF_CLEAR_T   = 2;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter with an end-of-phase compare.
//   clk, rst     : clock, synchronous active-high reset
//   i_clear      : zero the count on the next edge (new phase starts)
//   i_len        : length of the current phase in cycles (1..31)
//   o_count      : cycles spent in the current phase, 0-based
//   o_expire_c   : high on the last cycle of the phase (count == len-1)
module phase_timer
    import traffic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic [TIMER_W-1:0] i_len,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_expire_c
);

    logic [TIMER_W-1:0] r_count;

    // Free-running within a phase; wraps harmlessly in the untimed PREEMPT state.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_expire_c = (r_count == (i_len - TIMER_W'(1)));

endmodule

// File: rtl/intersection_controller.sv
// Two-direction traffic intersection controller with protected left arrows,
// demand-actuated greens and emergency-vehicle preemption.
//   clk, rst                   : clock, synchronous active-high reset
//   emergency                  : level, preempt to all-red
//   ns_car, ew_car             : level, vehicle waiting at that approach
//   ns_left_req, ew_left_req   : left-turn demand, latched until served
//   ns_light, ew_light         : lamp codes {left, green, yellow, red}
//   phase                      : current state code (traffic_pkg::state_t)
//   preempt_active             : high in PREEMPT and in the RELEASE clearance
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int unsigned LEFT_T    = DEF_LEFT_T,
    parameter int unsigned GREEN_MIN = DEF_GREEN_MIN,
    parameter int unsigned GREEN_MAX = DEF_GREEN_MAX,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned CLEAR_T   = DEF_CLEAR_T
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               emergency,
    input  logic               ns_car,
    input  logic               ew_car,
    input  logic               ns_left_req,
    input  logic               ew_left_req,
    output logic [LAMP_W-1:0]  ns_light,
    output logic [LAMP_W-1:0]  ew_light,
    output logic [STATE_W-1:0] phase,
    output logic               preempt_active
);

    // A minimum longer than the maximum collapses onto the maximum.
    localparam int unsigned GREEN_MIN_EFF = (GREEN_MIN > GREEN_MAX) ? GREEN_MAX : GREEN_MIN;

    localparam logic [TIMER_W-1:0] LEN_LEFT   = TIMER_W'(LEFT_T);
    localparam logic [TIMER_W-1:0] LEN_GREEN  = TIMER_W'(GREEN_MAX);
    localparam logic [TIMER_W-1:0] LEN_YELLOW = TIMER_W'(YELLOW_T);
    localparam logic [TIMER_W-1:0] LEN_CLEAR  = TIMER_W'(CLEAR_T);
    localparam logic [TIMER_W-1:0] GMIN_LAST  = TIMER_W'(GREEN_MIN_EFF - 1);

    state_t             r_state;
    state_t             w_next;
    state_t             w_ns_start;
    state_t             w_ew_start;
    logic               r_pend_ns;
    logic               r_pend_ew;
    logic               w_pend_ns;
    logic               w_pend_ew;
    logic               r_last_ns;
    logic               w_last_ns;
    logic [TIMER_W-1:0] w_count;
    logic [TIMER_W-1:0] w_len;
    logic               w_expire;
    logic               w_clear;
    logic               w_ns_green_done;
    logic               w_ew_green_done;
    logic [LAMP_W-1:0]  w_ns_light;
    logic [LAMP_W-1:0]  w_ew_light;
    logic               w_preempt;

    // Phase length for the state currently being timed.
    always_comb begin
        w_len = LEN_CLEAR;
        case (r_state)
            NS_LEFT,   EW_LEFT:   w_len = LEN_LEFT;
            NS_GREEN,  EW_GREEN:  w_len = LEN_GREEN;
            NS_YELLOW, EW_YELLOW: w_len = LEN_YELLOW;
            default:              w_len = LEN_CLEAR;
        endcase
    end

    assign w_clear = (w_next != r_state);

    phase_timer u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_len      (w_len),
        .o_count    (w_count),
        .o_expire_c (w_expire)
    );

    // Green ends early on opposing demand once the minimum is served; w_expire is the maximum.
    assign w_ns_green_done = ((w_count >= GMIN_LAST) && (ew_car || r_pend_ew)) || w_expire;
    assign w_ew_green_done = ((w_count >= GMIN_LAST) && (ns_car || r_pend_ns)) || w_expire;
    assign w_ns_start      = r_pend_ns ? NS_LEFT : NS_GREEN;
    assign w_ew_start      = r_pend_ew ? EW_LEFT : EW_GREEN;

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= CLEAR_EW;
            r_pend_ns      <= 1'b0;
            r_pend_ew      <= 1'b0;
            r_last_ns      <= 1'b0;
            ns_light       <= LAMP_RED;
            ew_light       <= LAMP_RED;
            preempt_active <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_pend_ns      <= w_pend_ns;
            r_pend_ew      <= w_pend_ew;
            r_last_ns      <= w_last_ns;
            ns_light       <= w_ns_light;
            ew_light       <= w_ew_light;
            preempt_active <= w_preempt;
        end
    end

    // Next state, left-turn latches and last-served direction.
    always_comb begin
        w_next    = r_state;
        w_pend_ns = r_pend_ns | ns_left_req;
        w_pend_ew = r_pend_ew | ew_left_req;
        w_last_ns = r_last_ns;

        case (r_state)
            NS_LEFT:   if (emergency) w_next = NS_YELLOW; else if (w_expire) w_next = NS_GREEN;
            NS_GREEN:  if (emergency || w_ns_green_done) w_next = NS_YELLOW;
            NS_YELLOW: if (w_expire) w_next = CLEAR_NS;
            CLEAR_NS:  if (w_expire) w_next = emergency ? PREEMPT : w_ew_start;
            EW_LEFT:   if (emergency) w_next = EW_YELLOW; else if (w_expire) w_next = EW_GREEN;
            EW_GREEN:  if (emergency || w_ew_green_done) w_next = EW_YELLOW;
            EW_YELLOW: if (w_expire) w_next = CLEAR_EW;
            CLEAR_EW:  if (w_expire) w_next = emergency ? PREEMPT : w_ns_start;
            PREEMPT:   if (!emergency) w_next = RELEASE;
            RELEASE: begin
                if (emergency) begin
                    w_next = PREEMPT;
                end else if (w_expire) begin
                    w_next = r_last_ns ? w_ew_start : w_ns_start;
                end
            end
            default:   w_next = CLEAR_EW;
        endcase

        // Entering the arrow services the request, including one arriving this cycle.
        if ((w_next == NS_LEFT) && (r_state != NS_LEFT)) w_pend_ns = 1'b0;
        if ((w_next == EW_LEFT) && (r_state != EW_LEFT)) w_pend_ew = 1'b0;

        if ((w_next == NS_LEFT) || (w_next == NS_GREEN)) begin
            w_last_ns = 1'b1;
        end else if ((w_next == EW_LEFT) || (w_next == EW_GREEN)) begin
            w_last_ns = 1'b0;
        end
    end

    // Lamp decode of the next state so lamps change on the same edge as phase.
    always_comb begin
        w_ns_light = LAMP_RED;
        w_ew_light = LAMP_RED;
        w_preempt  = 1'b0;
        case (w_next)
            NS_LEFT:   w_ns_light = LAMP_LEFT_RED;
            NS_GREEN:  w_ns_light = LAMP_GREEN;
            NS_YELLOW: w_ns_light = LAMP_YELLOW;
            EW_LEFT:   w_ew_light = LAMP_LEFT_RED;
            EW_GREEN:  w_ew_light = LAMP_GREEN;
            EW_YELLOW: w_ew_light = LAMP_YELLOW;
            PREEMPT,
            RELEASE:   w_preempt  = 1'b1;
            default:   w_preempt  = 1'b0;
        endcase
    end

    assign phase = r_state;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed scenarios followed
// by randomized traffic, all checked against a direction/phase-kind model.
module tb_intersection_controller;
    import traffic_pkg::*;

    localparam int unsigned P_LEFT   = 5;
    localparam int unsigned P_GMIN   = 6;
    localparam int unsigned P_GMAX   = 15;
    localparam int unsigned P_YELLOW = 3;
    localparam int unsigned P_CLEAR  = 2;

    localparam int K_LEFT = 0;
    localparam int K_GRN  = 1;
    localparam int K_YEL  = 2;
    localparam int K_CLR  = 3;
    localparam int K_PRE  = 4;
    localparam int K_REL  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       emergency = 1'b0;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ns_left_req = 1'b0;
    logic       ew_left_req = 1'b0;
    logic [3:0] ns_light;
    logic [3:0] ew_light;
    logic [3:0] phase;
    logic       preempt_active;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase kind, direction it serves (0 NS, 1 EW), cycles in phase.
    int m_kind = K_CLR;
    bit m_dir  = 1'b1;
    int m_age  = 0;
    bit m_pend [2];
    bit m_last = 1'b1;

    intersection_controller #(
        .LEFT_T    (P_LEFT),
        .GREEN_MIN (P_GMIN),
        .GREEN_MAX (P_GMAX),
        .YELLOW_T  (P_YELLOW),
        .CLEAR_T   (P_CLEAR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .emergency      (emergency),
        .ns_car         (ns_car),
        .ew_car         (ew_car),
        .ns_left_req    (ns_left_req),
        .ew_left_req    (ew_left_req),
        .ns_light       (ns_light),
        .ew_light       (ew_light),
        .phase          (phase),
        .preempt_active (preempt_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input int k);
        case (k)
            K_LEFT:  return int'(P_LEFT);
            K_GRN:   return int'(P_GMAX);
            K_YEL:   return int'(P_YELLOW);
            default: return int'(P_CLEAR);
        endcase
    endfunction

    function automatic int start_kind(input bit d);
        return m_pend[d] ? K_LEFT : K_GRN;
    endfunction

    // One clock edge of the reference behaviour, using the inputs present at that edge.
    task automatic model_step();
        int  nk;
        bit  nd;
        bit  entry;
        bit  done;
        bit  car [2];
        bit  req [2];
        int  gmin;
        gmin = (P_GMIN > P_GMAX) ? int'(P_GMAX) : int'(P_GMIN);
        car[0] = ns_car;      car[1] = ew_car;
        req[0] = ns_left_req; req[1] = ew_left_req;
        if (rst) begin
            m_kind = K_CLR; m_dir = 1'b1; m_age = 0;
            m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_last = 1'b1;
            return;
        end
        done = (m_age == len_of(m_kind) - 1);
        nk = m_kind;
        nd = m_dir;
        case (m_kind)
            K_LEFT: if (emergency) nk = K_YEL; else if (done) nk = K_GRN;
            K_GRN: begin
                if (emergency || m_age == int'(P_GMAX) - 1 ||
                    (m_age >= gmin - 1 && (car[!m_dir] || m_pend[!m_dir])))
                    nk = K_YEL;
            end
            K_YEL: if (done) nk = K_CLR;
            K_CLR: begin
                if (done) begin
                    if (emergency) nk = K_PRE;
                    else begin nd = !m_dir; nk = start_kind(nd); end
                end
            end
            K_PRE: if (!emergency) nk = K_REL;
            default: begin
                if (emergency) nk = K_PRE;
                else if (done) begin nd = !m_last; nk = start_kind(nd); end
            end
        endcase
        entry = (nk != m_kind) || (nd != m_dir);
        for (int d = 0; d < 2; d++) begin
            if (entry && nk == K_LEFT && nd == d[0]) m_pend[d] = 1'b0;
            else m_pend[d] = m_pend[d] | req[d];
        end
        if (nk == K_LEFT || nk == K_GRN) m_last = nd;
        m_kind = nk;
        m_dir  = nd;
        m_age  = entry ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
    endtask

    function automatic logic [3:0] exp_lamp(input bit d);
        if (m_dir != d) return 4'b0001;
        case (m_kind)
            K_LEFT:  return 4'b1001;
            K_GRN:   return 4'b0100;
            K_YEL:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [3:0] exp_phase();
        case (m_kind)
            K_LEFT:  return m_dir ? 4'(EW_LEFT)   : 4'(NS_LEFT);
            K_GRN:   return m_dir ? 4'(EW_GREEN)  : 4'(NS_GREEN);
            K_YEL:   return m_dir ? 4'(EW_YELLOW) : 4'(NS_YELLOW);
            K_CLR:   return m_dir ? 4'(CLEAR_EW)  : 4'(CLEAR_NS);
            K_PRE:   return 4'(PREEMPT);
            default: return 4'(RELEASE);
        endcase
    endfunction

    // Advance one cycle and compare all outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("phase", 32'(phase), 32'(exp_phase()));
        check("ns_light", 32'(ns_light), 32'(exp_lamp(1'b0)));
        check("ew_light", 32'(ew_light), 32'(exp_lamp(1'b1)));
        check("preempt_active", 32'(preempt_active),
              32'((m_kind == K_PRE) || (m_kind == K_REL)));
        check("both_non_red", 32'((ns_light != 4'b0001) && (ew_light != 4'b0001)), 32'd0);
    endtask

    // Count cycles spent in state st (including the current one), bounded.
    task automatic run_len(input logic [3:0] st, output int n);
        n = 0;
        while (phase == st && n < 64) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int k;
        int e_left;

        // Reset, then idle cycle.
        rst = 1'b1;
        tick();
        tick();
        check("rst_phase", 32'(phase), 32'(CLEAR_EW));
        check("rst_ns_light", 32'(ns_light), 32'h1);
        check("rst_preempt", 32'(preempt_active), 32'h0);
        rst = 1'b0;
        run_len(CLEAR_EW, n);  check("idle_clear_ew_len", 32'(n), 32'd2);
        run_len(NS_GREEN, n);  check("idle_ns_green_len", 32'(n), 32'd15);
        run_len(NS_YELLOW, n); check("idle_ns_yellow_len", 32'(n), 32'd3);
        run_len(CLEAR_NS, n);  check("idle_clear_ns_len", 32'(n), 32'd2);
        check("idle_then_ew_green", 32'(phase), 32'(EW_GREEN));

        // Left request during EW green gets one arrow on the next NS service.
        ns_left_req = 1'b1;
        tick();
        ns_left_req = 1'b0;
        run_len(EW_GREEN, n);
        run_len(EW_YELLOW, n);
        run_len(CLEAR_EW, n);
        check("left_entered", 32'(phase), 32'(NS_LEFT));
        check("left_lamp", 32'(ns_light), 32'h9);
        run_len(NS_LEFT, n);   check("left_len", 32'(n), 32'd5);
        check("left_then_green", 32'(ns_light), 32'h4);
        run_len(NS_GREEN, n);
        run_len(NS_YELLOW, n);
        run_len(CLEAR_NS, n);
        run_len(EW_GREEN, n);
        run_len(EW_YELLOW, n);
        run_len(CLEAR_EW, n);
        check("left_pending_cleared", 32'(phase), 32'(NS_GREEN));

        // Opposing car from the second green cycle: green lasts the minimum.
        tick();
        ew_car = 1'b1;
        run_len(NS_GREEN, n);
        check("green_min_len", 32'(n + 1), 32'd6);
        ew_car = 1'b0;
        run_len(NS_YELLOW, n);
        run_len(CLEAR_NS, n);
        run_len(EW_GREEN, n);
        run_len(EW_YELLOW, n);
        run_len(CLEAR_EW, n);

        // Emergency at green timer 3, held 10 cycles.
        for (int i = 0; i < 3; i++) tick();
        emergency = 1'b1;
        tick();
        check("emerg_to_yellow", 32'(phase), 32'(NS_YELLOW));
        run_len(NS_YELLOW, n); check("emerg_yellow_len", 32'(n), 32'd3);
        run_len(CLEAR_NS, n);  check("emerg_clear_len", 32'(n), 32'd2);
        check("emerg_preempt", 32'(phase), 32'(PREEMPT));
        for (int i = 0; i < 4; i++) tick();
        emergency = 1'b0;
        tick();
        check("release_preempt_active", 32'(preempt_active), 32'h1);
        run_len(RELEASE, n);   check("release_len", 32'(n), 32'd2);
        check("release_resume_ew", 32'(phase), 32'(EW_GREEN));

        // Emergency drops for one cycle and returns during RELEASE.
        emergency = 1'b1;
        tick();
        run_len(EW_YELLOW, n);
        run_len(CLEAR_EW, n);
        emergency = 1'b0;
        tick();
        check("release_entered", 32'(phase), 32'(RELEASE));
        emergency = 1'b1;
        tick();
        check("reenter_preempt", 32'(phase), 32'(PREEMPT));
        emergency = 1'b0;
        tick();
        run_len(RELEASE, n);
        check("resume_ns", 32'(phase), 32'(NS_GREEN));

        // Reset in the middle of EW yellow aborts straight to CLEAR_EW.
        k = 0;
        while (phase != EW_YELLOW && k < 100) begin k++; tick(); end
        check("reach_ew_yellow", 32'(phase), 32'(EW_YELLOW));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_phase", 32'(phase), 32'(CLEAR_EW));
        check("midrst_ns", 32'(ns_light), 32'h1);
        check("midrst_ew", 32'(ew_light), 32'h1);

        // Randomized traffic with emergency bursts and occasional reset.
        e_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (e_left > 0) begin
                e_left--;
                emergency = ($urandom_range(0, 15) != 0);
            end else begin
                emergency = 1'b0;
                if ($urandom_range(0, 59) == 0) e_left = int'($urandom_range(1, 20));
            end
            ns_car      = ($urandom_range(0, 3) == 0);
            ew_car      = ($urandom_range(0, 3) == 0);
            ns_left_req = ($urandom_range(0, 24) == 0);
            ew_left_req = ($urandom_range(0, 24) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
